// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch constants and redirect type
package fetch_pkg;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
  localparam logic [31:0] FETCH_STRIDE = 32'd8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_t;

  // Instruction fetch is word granular; low byte-offset bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/dual_fetch.sv
// rtl/dual_fetch.sv - dual-issue fetch stage reading word pairs through two ROM ports
module dual_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 14
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        a_imem_en,
  output logic [31:0] a_imem_addr,
  input  logic [31:0] a_imem_data,
  output logic        b_imem_en,
  output logic [31:0] b_imem_addr,
  input  logic [31:0] b_imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_a_insn,
  output logic [31:0] out_b_insn,
  output logic        out_b_valid
);

  localparam logic [ROM_AW-1:0] LAST_IDX = '1;

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic        issue;
  redirect_t   redir;

  always_comb begin
    redir.valid = redirect_valid;
    redir.pc    = align_pc(redirect_pc);
  end

  assign issue = !redir.valid && (!resp_valid || out_ready);

  // ROM output registers double as the hold buffer: a stalled pair is kept
  // simply by not re-enabling the read.
  assign a_imem_en   = issue && resetn;
  assign b_imem_en   = issue && resetn;
  assign a_imem_addr = fetch_pc;
  assign b_imem_addr = fetch_pc + 32'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      resp_valid <= 1'b0;
    end else if (redir.valid) begin
      fetch_pc   <= redir.pc;
      resp_valid <= 1'b0;
    end else if (issue) begin
      fetch_pc   <= fetch_pc + FETCH_STRIDE;
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
    end
  end

  assign out_valid  = resp_valid && !redir.valid;
  assign out_pc     = resp_pc;
  assign out_a_insn = out_valid ? a_imem_data : NOP_INSN;
  assign out_b_insn = out_valid ? b_imem_data : NOP_INSN;

  // Slot b wrapped around the ROM window when slot a is the last word.
  assign out_b_valid = out_valid && (resp_pc[ROM_AW+1:2] != LAST_IDX);

endmodule

// File: tb/tb_dual_fetch.sv
// tb/tb_dual_fetch.sv - scoreboard bench for dual_fetch
module tb_dual_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        bv;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_imem_en, b_imem_en;
  logic [31:0] a_imem_addr, b_imem_addr;
  logic [31:0] a_imem_data = 32'h0;
  logic [31:0] b_imem_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, out_b_valid;
  logic [31:0] out_pc, out_a_insn, out_b_insn;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dual_fetch dut (
    .clk(clk), .resetn(resetn),
    .a_imem_en(a_imem_en), .a_imem_addr(a_imem_addr), .a_imem_data(a_imem_data),
    .b_imem_en(b_imem_en), .b_imem_addr(b_imem_addr), .b_imem_data(b_imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_a_insn(out_a_insn), .out_b_insn(out_b_insn), .out_b_valid(out_b_valid)
  );

  function automatic logic [31:0] rom_word(input logic [13:0] idx);
    return {8'hC3, 2'b00, idx, 8'h5A};
  endfunction

  always @(posedge clk) begin
    if (a_imem_en) a_imem_data <= rom_word(a_imem_addr[15:2]);
    if (b_imem_en) b_imem_data <= rom_word(b_imem_addr[15:2]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_pair: got pc %h expected no pair", out_pc);
      end else begin
        mon_e = q.pop_front();
        chk("pair_pc", out_pc, mon_e.pc);
        chk("pair_a", out_a_insn, rom_word(mon_e.pc[15:2]));
        chk("pair_bv", {31'b0, out_b_valid}, {31'b0, mon_e.bv});
        if (mon_e.bv) chk("pair_b", out_b_insn, rom_word(mon_e.pc[15:2] + 14'd1));
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic bv);
    exp_t e;
    e.pc = pc;
    e.bv = bv;
    q.push_back(e);
  endtask

  task automatic set_in(input logic r, input logic rv, input logic [31:0] rpc);
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_en"}, {31'b0, a_imem_en}, 32'd0);
    chk({tag, "_b_en"}, {31'b0, b_imem_en}, 32'd0);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_bvalid"}, {31'b0, out_b_valid}, 32'd0);
    chk({tag, "_a_insn"}, out_a_insn, 32'h0000_0013);
    chk({tag, "_b_insn"}, out_b_insn, 32'h0000_0013);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_a_addr"}, a_imem_addr, 32'h0);
    chk({tag, "_b_addr"}, b_imem_addr, 32'h4);
  endtask

  logic [31:0] targets [6] = '{32'h0000_0200, 32'h1234_5676, 32'h0000_FFEC,
                               32'h0000_7FFE, 32'hFFFF_FFF8, 32'h0000_0040};

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    set_in(1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // streaming from reset, then a three-cycle stall on pc 0x18
    push(32'h00, 1'b1); push(32'h08, 1'b1); push(32'h10, 1'b1); push(32'h18, 1'b1);
    resetn = 1'b1;
    set_in(1'b1, 1'b0, 32'h0);
    repeat (4) tick();
    set_in(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_en", {31'b0, a_imem_en}, 32'd0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, 32'h18);
      chk("stall_a", out_a_insn, 32'hC300_065A);
      chk("stall_b", out_b_insn, 32'hC300_075A);
      tick();
    end
    set_in(1'b1, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 32'h0);
    chk("release_pc", out_pc, 32'h20);
    tick();

    // redirect coincident with out_ready while 0x20 is pending
    set_in(1'b1, 1'b1, 32'h0000_0106);
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_en", {31'b0, a_imem_en}, 32'd0);
    tick();
    set_in(1'b1, 1'b0, 32'h0);
    chk("bubble_valid", {31'b0, out_valid}, 32'd0);
    chk("bubble_addr", a_imem_addr, 32'h104);
    chk("bubble_en", {31'b0, a_imem_en}, 32'd1);
    push(32'h104, 1'b1); push(32'h10C, 1'b1);
    repeat (3) tick();

    // last ROM word: slot b wraps and is masked
    set_in(1'b1, 1'b1, 32'h0000_FFFC);
    push(32'h0000_FFFC, 1'b0); push(32'h0001_0004, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    set_in(1'b0, 1'b0, 32'h0);
    chk("pre_reset_pc", out_pc, 32'h0001_000C);
    tick();

    // asynchronous reset during a stall
    resetn = 1'b0;
    #1;
    chk_reset_outputs("async");
    repeat (2) tick();
    push(32'h00, 1'b1); push(32'h08, 1'b1);
    resetn = 1'b1;
    set_in(1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    set_in(1'b0, 1'b0, 32'h0);
    chk("directed_drain", q.size(), 32'd0);
    q.delete();

    // random back-pressure with a redirect per segment
    for (int s = 0; s < 6; s++) begin
      int k;
      int budget;
      logic [31:0] base;
      base = targets[s] & ~32'h3;
      k = $urandom_range(3, 7);
      for (int j = 0; j < k; j++) begin
        logic [31:0] p;
        p = base + 32'(8 * j);
        push(p, p[15:2] != 14'h3FFF);
      end
      set_in(1'($urandom_range(0, 1)), 1'b1, targets[s]);
      tick();
      budget = 0;
      while (q.size() != 0 && budget < 200) begin
        set_in(1'($urandom_range(0, 1)), 1'b0, 32'h0);
        tick();
        budget++;
      end
      chk("seg_drain", q.size(), 32'd0);
      q.delete();
    end
    set_in(1'b0, 1'b0, 32'h0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_fetch.md
# dual_fetch

Dual-issue instruction fetch stage feeding the two synchronous instruction ROM read ports (1-cycle registered read; output register holds when its enable is low). Each issue reads the aligned word pair at fetch PC and PC+4 through ports a and b, and presents the pair to decode under a valid/ready handshake. Branch/jump redirects from execute flush in-flight reads and restart fetch at the new PC. Stalls are absorbed by gating the ROM enables, so the ROM output registers act as the hold buffer and no extra storage is needed.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset
- ROM_AW, 14, word-index width of the ROM window (ROM index = addr[ROM_AW+1:2])

- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- a_imem_en  out  1  ROM port a read enable
- a_imem_addr  out  32  ROM port a byte address
- a_imem_data  in  32  ROM port a read data, valid the cycle after an enabled read
- b_imem_en  out  1  ROM port b read enable
- b_imem_addr  out  32  ROM port b byte address
- b_imem_data  in  32  ROM port b read data
- redirect_valid  in  1  single-cycle redirect request from execute
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- out_valid  out  1  instruction pair available to decode
- out_ready  in  1  decode accepts the pair this cycle
- out_pc  out  32  PC of slot a
- out_a_insn  out  32  slot a instruction
- out_b_insn  out  32  slot b instruction (PC out_pc+4)
- out_b_valid  out  1  slot b usable; low when slot a is the last ROM word

## Operation
- State: fetch_pc (32), resp_valid (1), resp_pc (32). Reset: fetch_pc=RESET_PC, resp_valid=0, resp_pc=RESET_PC.
- issue = !redirect_valid && (!resp_valid || out_ready). a_imem_en = b_imem_en = issue.
- a_imem_addr = fetch_pc; b_imem_addr = fetch_pc+4 (32-bit modulo add). Both driven every cycle, independent of issue.
- On issue: resp_valid<=1, resp_pc<=fetch_pc, fetch_pc<=fetch_pc+8.
- resp_valid && !out_ready && !redirect_valid: enables low, all state held; ROM output registers keep the pair stable.
- resp_valid && out_ready, no redirect: pair consumed and next pair issued in the same cycle (back-to-back throughput one pair/cycle).
- redirect_valid (priority over everything): enables low, resp_valid<=0, fetch_pc<={redirect_pc[31:2],2'b00}. A pending or in-flight pair is discarded.
- out_valid = resp_valid && !redirect_valid. out_pc = resp_pc.
- out_a_insn/out_b_insn = a/b_imem_data when out_valid, else NOP_INSN.
- out_b_valid = out_valid && (resp_pc[ROM_AW+1:2] != all ones). ROM index wraps; the wrapped word is never presented as valid.
- Redirect targets with pc[2]=1 are legal; pair is simply non-8-aligned.

## Timing
- Reset values: a_imem_en=b_imem_en=0, out_valid=0, out_b_valid=0, out_a/b_insn=NOP_INSN, out_pc=RESET_PC, a_imem_addr=RESET_PC, b_imem_addr=RESET_PC+4.
- First issue: first clk edge after resetn deasserts; out_valid high the following cycle.
- Fetch latency: issue at edge N -> pair valid in cycle N+1.
- Redirect at cycle R -> issue at R+1 -> out_valid at R+2 with out_pc=target (2-cycle bubble).
- Redirect coincident with out_ready: pair not accepted (out_valid already low).
- resetn asserted mid-operation: all state clears immediately; in-flight read ignored.
- No combinational path from out_ready or redirect_valid to out_pc; only to enables, out_valid and insn muxes.

## Structure
- Shared package fetch_pkg: NOP_INSN = 32'h0000_0013, FETCH_STRIDE = 8, redirect struct (valid, pc) for execute.
- Single flat module; no sub-module warranted.

## Test plan
- Reset release, out_ready=1, RESET_PC=0 -> pairs at out_pc 0,8,16,... every cycle; insns match ROM words 0/1, 2/3, 4/5.
- Hold out_ready=0 for 3 cycles after first pair -> enables low, out_pc=0 and insns stable 3 cycles; on release next out_pc=8 the cycle after.
- redirect_valid with redirect_pc=32'h0000_0106 while a pair is pending -> out_valid low 2 cycles, then out_pc=0x104, slot b = ROM word at 0x108.
- Redirect to 32'h0000_FFFC (ROM_AW=14) -> out_b_valid=0, out_a_insn = last ROM word; next out_pc=0x10004 with b valid.
- resetn pulsed low mid-stall -> outputs return to reset values asynchronously; fetch restarts at RESET_PC.
- Random out_ready and sparse redirects vs reference PC model -> every accepted pair matches the expected PC sequence, none lost or duplicated.
